// File: rtl/shr_harness_pkg.sv
// Shared types and width helpers for the serial pin harness.
package shr_harness_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        UNLOAD
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous load that overrides counting.
module sat_counter
    import shr_harness_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/shr_pin_harness.sv
// Serial-in stimulus register, frame-checked load, delayed capture of the
// primitive's outputs and serial MSB-first unload with a valid qualifier.
module shr_pin_harness
    import shr_harness_pkg::*;
#(
    parameter int DIN_N   = 8,
    parameter int DOUT_N  = 8,
    parameter int CAP_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              di,
    input  logic              di_vld,
    input  logic              stb,
    output logic [DIN_N-1:0]  din_o,
    input  logic [DOUT_N-1:0] dout_i,
    output logic              do_o,
    output logic              do_vld,
    output logic              busy,
    output logic              frame_err
);

    localparam int BW = clog2(DIN_N + 2);
    localparam int CW = clog2(max2(CAP_DLY, DOUT_N) + 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(DIN_N);

    state_t            state_q, state_d;
    logic [DIN_N-1:0]  din_shr_q, din_shr_d;
    logic [DIN_N-1:0]  din_q, din_d;
    logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [DIN_N-1:0]  din_nxt;
    logic [BW-1:0]     bit_cnt;
    logic              accept;
    logic              bit_load;

    if (DIN_N == 1) begin : g_shr1
        assign din_nxt = di;
    end else begin : g_shrn
        assign din_nxt = {din_shr_q[DIN_N-2:0], di};
    end

    assign accept   = stb && (state_q == IDLE) && (bit_cnt == BIT_FULL);
    // any strobe seen in IDLE restarts framing, keeping a same-cycle bit
    assign bit_load = stb && (state_q == IDLE);

    sat_counter #(
        .W   (BW),
        .MAX (DIN_N + 1)
    ) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bit_load),
        .load_val (BW'(di_vld)),
        .inc      (di_vld),
        .cnt      (bit_cnt)
    );

    always_comb begin
        state_d     = state_q;
        din_shr_d   = din_shr_q;
        din_d       = din_q;
        dout_shr_d  = dout_shr_q;
        cnt_d       = cnt_q;
        frame_err_d = stb && !accept;
        if (di_vld) begin
            din_shr_d = din_nxt;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    din_d   = din_shr_q;
                    cnt_d   = CW'(CAP_DLY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    dout_shr_d = dout_i;
                    cnt_d      = CW'(DOUT_N);
                    state_d    = UNLOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UNLOAD: begin
                dout_shr_d = dout_shr_q << 1;
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            din_shr_q   <= '0;
            din_q       <= '0;
            dout_shr_q  <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_shr_q   <= din_shr_d;
            din_q       <= din_d;
            dout_shr_q  <= dout_shr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign din_o     = din_q;
    assign busy      = (state_q != IDLE);
    assign do_vld    = (state_q == UNLOAD);
    assign do_o      = do_vld && dout_shr_q[DOUT_N-1];
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_shr_pin_harness.sv
// Directed bench: default harness plus two corner-parameter instances.
module tb_shr_pin_harness;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        di = 1'b0, di_vld = 1'b0, stb = 1'b0;
    logic [7:0]  din_o;
    logic [7:0]  dout_i = 8'h00;
    logic        do_o, do_vld, busy, frame_err;

    logic        a_di = 1'b0, a_vld = 1'b0, a_stb = 1'b0;
    logic [0:0]  a_din;
    logic [0:0]  a_dout = 1'b0;
    logic        a_do, a_dvld, a_busy, a_ferr;

    logic        b_di = 1'b0, b_vld = 1'b0, b_stb = 1'b0;
    logic [35:0] b_din;
    logic [31:0] b_dout = 32'h0;
    logic        b_do, b_dvld, b_busy, b_ferr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shr_pin_harness u_dut (
        .clk(clk), .rst_n(rst_n), .di(di), .di_vld(di_vld), .stb(stb),
        .din_o(din_o), .dout_i(dout_i), .do_o(do_o), .do_vld(do_vld),
        .busy(busy), .frame_err(frame_err)
    );

    shr_pin_harness #(.DIN_N(1), .DOUT_N(1), .CAP_DLY(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .di(a_di), .di_vld(a_vld), .stb(a_stb),
        .din_o(a_din), .dout_i(a_dout), .do_o(a_do), .do_vld(a_dvld),
        .busy(a_busy), .frame_err(a_ferr)
    );

    shr_pin_harness #(.DIN_N(36), .DOUT_N(32), .CAP_DLY(5)) u_s2 (
        .clk(clk), .rst_n(rst_n), .di(b_di), .di_vld(b_vld), .stb(b_stb),
        .din_o(b_din), .dout_i(b_dout), .do_o(b_do), .do_vld(b_dvld),
        .busy(b_busy), .frame_err(b_ferr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_n(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            di = v[i];
            di_vld = 1'b1;
            step();
        end
        di_vld = 1'b0;
        di = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (din_o !== 8'h00) begin n_bad++; $display("FAIL reset din_o act=%h req=00", din_o); end
        n_cmp++; if (do_o !== 1'b0) begin n_bad++; $display("FAIL reset do act=%b req=0", do_o); end
        n_cmp++; if (do_vld !== 1'b0) begin n_bad++; $display("FAIL reset do_vld act=%b req=0", do_vld); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy act=%b req=0", busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset frame_err act=%b req=0", frame_err); end
        n_cmp++; if (a_busy !== 1'b0 || a_din !== 1'b0) begin n_bad++; $display("FAIL reset s1 busy/din act=%b/%b req=0/0", a_busy, a_din); end
        n_cmp++; if (b_busy !== 1'b0 || b_din !== 36'h0) begin n_bad++; $display("FAIL reset s2 busy/din act=%b/%h req=0/0", b_busy, b_din); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame_load();
        logic [7:0] dv;
        logic ev, eb, ed, ferr;
        dv = 8'h3C;
        dout_i = dv;
        ferr = 1'b0;
        shift_n(16'h00A5, 8);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'hA5) begin n_bad++; $display("FAIL load din_o act=%h req=a5", din_o); end
        for (int k = 1; k <= 11; k++) begin
            ev = (k >= 3 && k <= 10);
            eb = (k <= 10);
            ed = 1'b0;
            if (ev) ed = dv[10-k];
            n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL load busy k=%0d act=%b req=%b", k, busy, eb); end
            n_cmp++; if (do_vld !== ev) begin n_bad++; $display("FAIL load do_vld k=%0d act=%b req=%b", k, do_vld, ev); end
            n_cmp++; if (do_o !== ed) begin n_bad++; $display("FAIL load do k=%0d act=%b req=%b", k, do_o, ed); end
            if (frame_err) ferr = 1'b1;
            step();
        end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL load frame_err seen act=%b req=0", ferr); end
    endtask

    task automatic test_short_overrun();
        shift_n(16'h0033, 7);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short frame_err act=%b req=1", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL short busy act=%b req=0", busy); end
        n_cmp++; if (din_o !== 8'hA5) begin n_bad++; $display("FAIL short din_o act=%h req=a5", din_o); end
        step();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short pulse len act=%b req=0", frame_err); end
        shift_n(16'h01FF, 9);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL overrun frame_err act=%b req=1", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overrun busy act=%b req=0", busy); end
        n_cmp++; if (din_o !== 8'hA5) begin n_bad++; $display("FAIL overrun din_o act=%h req=a5", din_o); end
        step();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL overrun pulse len act=%b req=0", frame_err); end
    endtask

    task automatic test_stb_busy();
        logic [7:0] dv;
        logic ev, eb, ed, ef;
        dv = 8'h96;
        dout_i = dv;
        shift_n(16'h00C3, 8);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'hC3) begin n_bad++; $display("FAIL busy_stb din_o act=%h req=c3", din_o); end
        for (int k = 1; k <= 12; k++) begin
            ev = (k >= 3 && k <= 10);
            eb = (k <= 10);
            ef = (k == 2 || k == 6);
            ed = 1'b0;
            if (ev) ed = dv[10-k];
            n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL busy_stb busy k=%0d act=%b req=%b", k, busy, eb); end
            n_cmp++; if (do_vld !== ev) begin n_bad++; $display("FAIL busy_stb do_vld k=%0d act=%b req=%b", k, do_vld, ev); end
            n_cmp++; if (do_o !== ed) begin n_bad++; $display("FAIL busy_stb do k=%0d act=%b req=%b", k, do_o, ed); end
            n_cmp++; if (frame_err !== ef) begin n_bad++; $display("FAIL busy_stb frame_err k=%0d act=%b req=%b", k, frame_err, ef); end
            stb = (k == 1 || k == 5);
            step();
        end
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'hC3) begin n_bad++; $display("FAIL busy_stb din_o kept act=%h req=c3", din_o); end
    endtask

    task automatic test_preshift();
        logic [7:0] dv, nv;
        logic ev, ed;
        dv = 8'hF0;
        nv = 8'h5A;
        dout_i = dv;
        shift_n(16'h0011, 8);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'h11) begin n_bad++; $display("FAIL preshift din_o act=%h req=11", din_o); end
        for (int k = 1; k <= 11; k++) begin
            ev = (k >= 3 && k <= 10);
            ed = 1'b0;
            if (ev) ed = dv[10-k];
            n_cmp++; if (do_vld !== ev) begin n_bad++; $display("FAIL preshift do_vld k=%0d act=%b req=%b", k, do_vld, ev); end
            n_cmp++; if (do_o !== ed) begin n_bad++; $display("FAIL preshift do k=%0d act=%b req=%b", k, do_o, ed); end
            di_vld = ev;
            di = 1'b0;
            if (ev) di = nv[10-k];
            if (k == 11) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL preshift idle busy act=%b req=0", busy); end
                stb = 1'b1;
            end
            step();
        end
        stb = 1'b0;
        di_vld = 1'b0;
        n_cmp++; if (din_o !== 8'h5A) begin n_bad++; $display("FAIL preshift din_o next act=%h req=5a", din_o); end
        n_cmp++; if (busy !== 1'b1 || frame_err !== 1'b0) begin n_bad++; $display("FAIL preshift accept busy/ferr act=%b/%b req=1/0", busy, frame_err); end
        for (int i = 0; i < 20 && busy; i++) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL preshift drain busy act=%b req=0", busy); end
    endtask

    task automatic test_overlap();
        shift_n(16'h00E7, 8);
        di = 1'b1;
        di_vld = 1'b1;
        stb = 1'b1;
        step();
        stb = 1'b0;
        di_vld = 1'b0;
        n_cmp++; if (din_o !== 8'hE7) begin n_bad++; $display("FAIL overlap din_o first act=%h req=e7", din_o); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL overlap first ferr act=%b req=0", frame_err); end
        shift_n(16'h0035, 7);
        for (int i = 0; i < 20 && busy; i++) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overlap wait busy act=%b req=0", busy); end
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'hB5) begin n_bad++; $display("FAIL overlap din_o second act=%h req=b5", din_o); end
        n_cmp++; if (frame_err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL overlap second ferr/busy act=%b/%b req=0/1", frame_err, busy); end
        for (int i = 0; i < 20 && busy; i++) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overlap drain busy act=%b req=0", busy); end
    endtask

    task automatic test_reset_mid_unload();
        logic seen;
        dout_i = 8'hFF;
        shift_n(16'h006C, 8);
        stb = 1'b1;
        step();
        stb = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        n_cmp++; if (do_vld !== 1'b1 || do_o !== 1'b1) begin n_bad++; $display("FAIL rstmid pre vld/do act=%b/%b req=1/1", do_vld, do_o); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (din_o !== 8'h00) begin n_bad++; $display("FAIL rstmid din_o act=%h req=00", din_o); end
        n_cmp++; if (do_vld !== 1'b0 || do_o !== 1'b0) begin n_bad++; $display("FAIL rstmid vld/do act=%b/%b req=0/0", do_vld, do_o); end
        n_cmp++; if (busy !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid busy/ferr act=%b/%b req=0/0", busy, frame_err); end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (do_vld) seen = 1'b1;
            step();
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid stale do_vld act=%b req=0", seen); end
        dout_i = 8'h81;
        shift_n(16'h009D, 8);
        stb = 1'b1;
        step();
        stb = 1'b0;
        n_cmp++; if (din_o !== 8'h9D || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid fresh din_o/busy act=%h/%b req=9d/1", din_o, busy); end
        step();
        step();
        n_cmp++; if (do_vld !== 1'b1 || do_o !== 1'b1) begin n_bad++; $display("FAIL rstmid fresh vld/do act=%b/%b req=1/1", do_vld, do_o); end
        step();
        n_cmp++; if (do_o !== 1'b0) begin n_bad++; $display("FAIL rstmid fresh bit6 act=%b req=0", do_o); end
        for (int i = 0; i < 20 && busy; i++) step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid drain busy act=%b req=0", busy); end
    endtask

    task automatic test_sweep();
        logic [35:0] bv;
        logic [31:0] dv;
        logic ev, eb, ed;
        a_dout = 1'b1;
        a_di = 1'b1;
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        a_stb = 1'b1;
        step();
        a_stb = 1'b0;
        n_cmp++; if (a_din !== 1'b1 || a_busy !== 1'b1 || a_dvld !== 1'b0) begin n_bad++; $display("FAIL s1 T+1 din/busy/vld act=%b/%b/%b req=1/1/0", a_din, a_busy, a_dvld); end
        a_di = 1'b0;
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        n_cmp++; if (a_dvld !== 1'b1 || a_do !== 1'b1 || a_busy !== 1'b1) begin n_bad++; $display("FAIL s1 T+2 vld/do/busy act=%b/%b/%b req=1/1/1", a_dvld, a_do, a_busy); end
        step();
        n_cmp++; if (a_dvld !== 1'b0 || a_do !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL s1 T+3 vld/do/busy act=%b/%b/%b req=0/0/0", a_dvld, a_do, a_busy); end
        a_stb = 1'b1;
        step();
        a_stb = 1'b0;
        n_cmp++; if (a_din !== 1'b0 || a_busy !== 1'b1 || a_ferr !== 1'b0) begin n_bad++; $display("FAIL s1 back2back din/busy/ferr act=%b/%b/%b req=0/1/0", a_din, a_busy, a_ferr); end
        for (int i = 0; i < 10 && a_busy; i++) step();
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL s1 drain busy act=%b req=0", a_busy); end

        bv = 36'h9_A5C3_1E7F;
        dv = 32'hDEAD_BEEF;
        b_dout = dv;
        for (int i = 35; i >= 0; i--) begin
            b_di = bv[i];
            b_vld = 1'b1;
            step();
        end
        b_vld = 1'b0;
        b_stb = 1'b1;
        step();
        b_stb = 1'b0;
        n_cmp++; if (b_din !== bv) begin n_bad++; $display("FAIL s2 din_o act=%h req=%h", b_din, bv); end
        for (int k = 1; k <= 38; k++) begin
            ev = (k >= 6 && k <= 37);
            eb = (k <= 37);
            ed = 1'b0;
            if (ev) ed = dv[37-k];
            n_cmp++; if (b_busy !== eb) begin n_bad++; $display("FAIL s2 busy k=%0d act=%b req=%b", k, b_busy, eb); end
            n_cmp++; if (b_dvld !== ev) begin n_bad++; $display("FAIL s2 do_vld k=%0d act=%b req=%b", k, b_dvld, ev); end
            n_cmp++; if (b_do !== ed) begin n_bad++; $display("FAIL s2 do k=%0d act=%b req=%b", k, b_do, ed); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_frame_load();
        test_short_overrun();
        test_stb_busy();
        test_preshift();
        test_overlap();
        test_reset_mid_unload();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shr_pin_harness.md
# shr_pin_harness

Parametrised serial-to-parallel pin harness for primitive bitstream minitests. It shifts a serial stimulus stream into a DIN_N-bit register that drives the device-under-test pins. A frame-checked strobe loads the register. After a programmable settle delay the block captures the DUT's DOUT_N outputs and shifts them back out serially with a valid qualifier. It sits between the top-level `clk`/`di`/`stb`/`do` pads and the hard primitive being fuzzed.

## Interface
- `DIN_N`, default 8: stimulus width (≥1).
- `DOUT_N`, default 8: capture width (≥1).
- `CAP_DLY`, default 2: settle cycles between load and capture (≥1).
- `clk` in 1: sole clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `di` in 1: serial stimulus bit.
- `di_vld` in 1: `di` qualifier; bit shifted only when high.
- `stb` in 1: load request.
- `din_o` out DIN_N: parallel stimulus to DUT pins.
- `dout_i` in DOUT_N: DUT outputs.
- `do` out 1: serial capture bit, MSB first.
- `do_vld` out 1: high while `do` carries a captured bit.
- `busy` out 1: high in WAIT and UNLOAD.
- `frame_err` out 1: one-cycle pulse on a rejected `stb`.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE; `din_o`, shift registers, counters, `do`, `do_vld`, `busy` and `frame_err` are all 0. Reset mid-frame or mid-unload aborts it with no further `do_vld`.
- Input side runs in every state:
  - `di_vld`=1: `din_shr <= {din_shr[DIN_N-2:0], di}`.
  - Bit counter increments and saturates at DIN_N+1.
- States:
  - IDLE: accepts `stb`.
  - WAIT: counts down the settle delay. When the delay counter reaches 1, it samples `dout_i` into `dout_shr` and moves to UNLOAD.
  - UNLOAD: `do` = `dout_shr[DOUT_N-1]`, shifts left each cycle for exactly DOUT_N cycles, then IDLE.
- `stb` in IDLE with bit counter == DIN_N is accepted:
  - `din_o <= din_shr` (the value before any same-cycle shift).
  - Counter set to `di_vld`, so a same-cycle bit counts toward the next frame.
  - Delay counter loaded with CAP_DLY; state moves to WAIT.
- `stb` in IDLE with bit counter != DIN_N (short or overrun frame) is rejected:
  - `frame_err` pulses, `din_o` unchanged, counter cleared to `di_vld`, state stays IDLE.
- `stb` in WAIT or UNLOAD: `frame_err` pulses, otherwise ignored. The bit counter is untouched, so the next frame can be pre-shifted during unload.
- `din_o` changes only on an accepted `stb`.

## Timing
- Accepted `stb` sampled at edge T:
  - `din_o` is valid from cycle T+1.
  - `busy` rises at T+1.
  - WAIT occupies cycles T+1 … T+CAP_DLY.
  - `dout_i` is sampled at the edge ending cycle T+CAP_DLY.
  - `do_vld` is high for cycles T+CAP_DLY+1 … T+CAP_DLY+DOUT_N, carrying bits DOUT_N-1 down to 0.
  - `busy` falls and `do` returns to 0 at T+CAP_DLY+DOUT_N+1.
- Earliest next accepted `stb` is at cycle T+CAP_DLY+DOUT_N+1.
- `frame_err` is registered: it is high in the cycle after the offending `stb`, for exactly one cycle.
- No combinational path from inputs to outputs.

## Structure
- Package `shr_harness_pkg`:
  - `state_t` enum {IDLE, WAIT, UNLOAD}.
  - Function `clog2` for counter widths: bit counter `$clog2(DIN_N+2)`, delay/unload counter `$clog2(max(CAP_DLY,DOUT_N)+1)`.
- One sub-module, `sat_counter`, a parametrised saturating up-counter with synchronous load. Instantiate it for the input bit counter.
- FSM, delay/unload counter and both shift registers stay in the top.

## Test plan
- Frame load: DIN_N=8, CAP_DLY=2; shift 0xA5 MSB-first with `di_vld`=1, `stb` at T → `din_o`=0xA5 at T+1. With `dout_i` tied to 0x3C, `do_vld` is high T+3…T+10 with `do` = 0,0,1,1,1,1,0,0; `frame_err` never asserted.
- Short and overrun frames:
  - 7 bits then `stb` → `frame_err` pulse, `din_o` unchanged, `busy`=0.
  - 9 bits then `stb` → same result.
- Strobe while busy: `stb` during WAIT and again in the 3rd UNLOAD cycle → two `frame_err` pulses, unload sequence unaltered.
- Pre-shift overlap: during UNLOAD shift next frame 0x5A, `stb` in the first IDLE cycle → accepted, `din_o`=0x5A.
- Simultaneous `stb`+`di_vld`: 8 bits loaded, `stb` with `di`=1, `di_vld`=1, then 7 more bits, then `stb` → both accepted; the second frame includes the overlap bit as its MSB.
- Reset mid-unload: `rst_n`=0 on the 4th `do_vld` cycle → next cycle all outputs 0, state IDLE, a fresh 8-bit frame loads normally.
- Parameter sweep: DIN_N=1, DOUT_N=1, CAP_DLY=1 and DIN_N=36, DOUT_N=32, CAP_DLY=5 → cycle counts match the Timing section exactly.
